demux_router: RTL
=================

// Module: demux_router
// PURPOSE
//  Inverse of the datapath 2:1 mux: routes one WIDTH-bit input stream to one of two
//  output channels (first/second) chosen per word by inSel. Each channel has its own
//  DEPTH-entry FIFO with valid/ready handshakes. Sits between a result producer
//  (ALU/writeback) and two consumers (register-file write port, memory write port).
// PARAMETERS
//  WIDTH  8  data word width in bits
//  DEPTH  4  entries per channel FIFO; power of 2, >= 2
// PORTS
//  clk           in   1      single clock, all logic on rising edge
//  resetN        in   1      synchronous reset, active-low
//  inData        in   WIDTH  word offered by producer
//  inSel         in   1      0 -> first channel, 1 -> second channel
//  inValid       in   1      producer has a word on inData
//  inReady       out  1      selected channel can accept this cycle
//  firstData     out  WIDTH  head of first FIFO
//  firstValid    out  1      first FIFO not empty
//  firstReady    in   1      first consumer takes head this cycle
//  secondData    out  WIDTH  head of second FIFO
//  secondValid   out  1      second FIFO not empty
//  secondReady   in   1      second consumer takes head this cycle
// BEHAVIOUR
//  - Reset (resetN=0 at a rising edge): both FIFOs empty, pointers/occupancy 0,
//    firstValid=secondValid=0, firstData=secondData=0; inReady=1 once released.
//    Reset mid-operation discards all buffered words; nothing emitted afterwards.
//  - inReady = !full(inSel channel), combinational from inSel and registered occupancy.
//  - Push: inValid && inReady at edge -> inData written to tail of channel inSel.
//  - Pop: xValid && xReady at edge -> head of channel x removed.
//  - Latency: word pushed at edge N is visible (xValid=1, xData=word) after edge N;
//    no combinational input->output bypass.
//  - xData = head entry when xValid=1, else 0.
//  - Full: occupancy == DEPTH. Full uses registered occupancy only: a pop on a full
//    channel does not enable a push to it in the same cycle.
//  - Simultaneous push and pop on one non-full channel: both occur, occupancy unchanged,
//    order preserved. Push to one channel and pop from the other are independent.
//  - Full channel blocks only words routed to it; inSel may change while inValid is
//    high and not accepted; routing follows inSel at the accepting edge.
//  - xReady while xValid=0: ignored. Pointers wrap modulo DEPTH; occupancy
//    0..DEPTH; strict FIFO order per channel.
// CONFIGURATION
//  DEMUX_STATS_EN defined: extra ports firstCount, secondCount (out, 8 bits) count
//    accepted pushes per channel; reset to 0; wrap 255 -> 0; increment visible after
//    the accepting edge.
//  DEMUX_STATS_EN undefined: those ports and counters do not exist; all else identical.
// TESTING
//  1 resetN=0 for 2 cycles, then 1 -> firstValid=secondValid=0, data outputs 0, inReady=1.
//  2 inData=8'h08,inSel=0,inValid=1 one cycle, firstReady=0 -> next cycle firstValid=1,
//    firstData=8'h08, secondValid=0; firstReady=1 one cycle -> firstValid=0.
//  3 push 8'h02,8'h07,8'h04 with inSel=1, secondReady=1 -> secondData 02,07,04 in
//    consecutive cycles, each one cycle after its push; firstValid stays 0.
//  4 4 pushes inSel=0, firstReady=0 -> inReady=0 with inSel=0, inReady=1 with inSel=1;
//    8'h05 to second accepted; firstReady=1 plus push to first same cycle -> no push.
//  5 first occupancy 2, push 8'hAA and pop same cycle -> occupancy stays 2; pops
//    return older word, then 8'hAA.
//  6 3 words buffered per channel, resetN=0 one cycle -> both valids 0 next cycle; with
//    DEMUX_STATS_EN, 256 pushes to first -> firstCount=0, secondCount unchanged.

Source files
------------

// File: rtl/demux_router.sv
// 1:2 stream router: each word goes to the first or second channel FIFO chosen by inSel.
// Optional DEMUX_STATS_EN adds per-channel 8-bit accepted-push counters (firstCount/secondCount).
module demux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] inData,
  input  logic             inSel,
  input  logic             inValid,
  output logic             inReady,
`ifdef DEMUX_STATS_EN
  output logic [7:0]       firstCount,
  output logic [7:0]       secondCount,
`endif
  output logic [WIDTH-1:0] firstData,
  output logic             firstValid,
  input  logic             firstReady,
  output logic [WIDTH-1:0] secondData,
  output logic             secondValid,
  input  logic             secondReady
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]       full;
  logic [1:0]       head_valid;
  logic [WIDTH-1:0] head_data [2];
  logic [1:0]       out_ready;
`ifdef DEMUX_STATS_EN
  logic [7:0]       stat_cnt [2];
`endif

  assign out_ready = {secondReady, firstReady};

  // Full is taken from registered occupancy only, so a same-cycle pop never frees a slot.
  assign inReady = !full[inSel];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;

    assign full[ch]       = (occ == CW'(DEPTH));
    assign head_valid[ch] = (occ != '0);
    assign head_data[ch]  = head_valid[ch] ? mem[rd_ptr] : '0;
    assign push           = inValid && !full[ch] && (inSel == 1'(ch));
    assign pop            = head_valid[ch] && out_ready[ch];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (!resetN) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end

    // Storage needs no reset: head_data is gated by occupancy.
    always_ff @(posedge clk) begin
      if (resetN && push) mem[wr_ptr] <= inData;
    end

`ifdef DEMUX_STATS_EN
    logic [7:0] stat;
    always_ff @(posedge clk) begin
      if (!resetN)   stat <= '0;
      else if (push) stat <= stat + 8'(1);
    end
    assign stat_cnt[ch] = stat;
`endif
  end

  assign firstData   = head_data[0];
  assign firstValid  = head_valid[0];
  assign secondData  = head_data[1];
  assign secondValid = head_valid[1];
`ifdef DEMUX_STATS_EN
  assign firstCount  = stat_cnt[0];
  assign secondCount = stat_cnt[1];
`endif

endmodule
